// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer holding HI/LO.
// Shift-add multiply and restoring divide, one bit per cycle.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start, op    issue request; op 00 MULTU 01 MULT 10 DIVU 11 DIV
//   rs_val       multiplicand / dividend
//   rt_val       multiplier / divisor
//   cancel       flush; aborts the operation in flight
//   busy         high in RUN and FIX
//   done         one-cycle pulse when hi/lo carry a new result
//   stall_req    start while busy
//   hi, lo       architectural HI/LO
//   div_by_zero  last completed divide had a zero divisor
//
// Build option: define MULDIV_EARLY_OUT_EN to let multiplies leave
// RUN once the remaining multiplier bits are all zero.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic               neg_a, neg_b, b_zero;
  logic [WIDTH-1:0]   rs_orig;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;

  logic is_div;
  logic accept;
  logic last;
  logic run_end;

  assign is_div = op_q[1];
  assign accept = start & ~cancel &
                  ((state == S_IDLE) | (state == S_DONE));
  assign last   = (cnt == CW'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  assign run_end = last | (~is_div & ((mplier >> 1) == '0));
`else
  assign run_end = last;
`endif

  // Operand magnitudes at issue; neg flags only set for signed ops.
  logic             in_neg_a, in_neg_b;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;

  assign in_neg_a = op[0] & rs_val[WIDTH-1];
  assign in_neg_b = op[0] & rt_val[WIDTH-1];
  assign in_mag_a = in_neg_a ? -rs_val : rs_val;
  assign in_mag_b = in_neg_b ? -rt_val : rt_val;

  // Restoring divide step. mplier holds the dividend bits still
  // to be shifted in, with quotient bits filling in from the LSB.
  logic [WIDTH:0] rem_sh, trial;
  logic           q_bit;

  assign rem_sh = {rem, mplier[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvsr};
  assign q_bit  = ~trial[WIDTH];

  // Sign correction, evaluated while in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    quo_fix  = (neg_a ^ neg_b) ? -mplier : mplier;
    rem_fix  = neg_a ? -rem : rem;
    if (!is_div) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (b_zero) begin
      res_hi = rs_orig;
      res_lo = '1;
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = S_RUN;
      S_RUN: begin
        if (cancel)       state_nxt = S_IDLE;
        else if (run_end) state_nxt = S_FIX;
      end
      S_FIX:  state_nxt = cancel ? S_IDLE : S_DONE;
      S_DONE: state_nxt = accept ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_RUN) | (state == S_FIX);
    done      = (state == S_DONE);
    stall_req = start & busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      op_q        <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      b_zero      <= 1'b0;
      rs_orig     <= '0;
      mplier      <= '0;
      dvsr        <= '0;
      rem         <= '0;
      acc         <= '0;
      mcand       <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        cnt         <= '0;
        op_q        <= op;
        neg_a       <= in_neg_a;
        neg_b       <= in_neg_b;
        b_zero      <= (rt_val == '0);
        rs_orig     <= rs_val;
        mplier      <= op[1] ? in_mag_a : in_mag_b;
        dvsr        <= in_mag_b;
        rem         <= '0;
        acc         <= '0;
        mcand       <= {{WIDTH{1'b0}}, in_mag_a};
        div_by_zero <= 1'b0;
      end else if (state == S_RUN) begin
        cnt <= cnt + 1'b1;
        if (!is_div) begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end else begin
          rem    <= q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          mplier <= {mplier[WIDTH-2:0], q_bit};
        end
      end
      if (state == S_FIX && state_nxt == S_DONE) begin
        hi          <= res_hi;
        lo          <= res_lo;
        div_by_zero <= is_div & b_zero;
      end
    end
  end

endmodule
